tx_buffer_scheduler: RTL and testbench

- Shares one transmit port between NUM_BUF packet TX buffers.
- Grants whole packets, rotating round-robin between buffers.
- Enforces an inter-frame gap (IFG) after each packet.
- On a link collision, rewinds the granted buffer and retries after a binary-exponential backoff; drops the packet after MAX_RETRY retries.
- Sits between the TX buffers and the transmitter/PHY; replaces ad-hoc buffer selection with a sequenced scheduler.

---
 rtl/tx_buffer_scheduler_pkg.sv | 5 +
 rtl/tx_buffer_scheduler_rr.sv | 17 +
 rtl/tx_buffer_scheduler.sv | 85 ++++++++
 tb/tb_tx_buffer_scheduler.sv | 126 ++++++++++++
 4 files changed

// File: rtl/tx_buffer_scheduler_pkg.sv
// tx_buffer_scheduler_pkg: shared flit width and scheduler state encoding
package tx_buffer_scheduler_pkg;
  localparam int PKT_FLIT_W = 32;
  typedef enum logic [1:0] {IDLE, XFER, BACKOFF, GAP} sched_state_t;
endpackage

// File: rtl/tx_buffer_scheduler_rr.sv
// rr_arbiter_comb: round-robin pick starting just after last, purely combinational
module rr_arbiter_comb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any_req
);
  localparam int W = $clog2(N);
  always_comb begin
    grant = '0;
    for (int i = N; i > 0; i--)
      if (req[(int'(last) + i) % N]) grant = W'((int'(last) + i) % N);
  end
  assign any_req = |req;
endmodule

// File: rtl/tx_buffer_scheduler.sv
// tx_buffer_scheduler: round-robin packet scheduler with IFG and collision backoff/drop
module tx_buffer_scheduler
  import tx_buffer_scheduler_pkg::*;
#(
  parameter int NUM_BUF      = 4,
  parameter int FLIT_W       = PKT_FLIT_W,
  parameter int IFG          = 4,
  parameter int BACKOFF_UNIT = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BUF-1:0]          buf_valid,
  input  logic [NUM_BUF*FLIT_W-1:0]   buf_flit,
  input  logic [NUM_BUF-1:0]          buf_tail,
  output logic [NUM_BUF-1:0]          buf_pop,
  output logic [NUM_BUF-1:0]          buf_rewind,
  output logic [NUM_BUF-1:0]          buf_discard,
  output logic                        tx_valid,
  output logic [FLIT_W-1:0]           tx_flit,
  output logic                        tx_tail,
  input  logic                        tx_ready,
  input  logic                        tx_collision,
  output logic [$clog2(NUM_BUF)-1:0]  grant_id,
  output logic                        busy,
  output logic                        drop
);
  localparam int GW = $clog2(NUM_BUF);
  localparam int CW = $clog2(BACKOFF_UNIT << MAX_RETRY) + 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  sched_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic [GW-1:0] last_grant, arb_grant;
  logic [NUM_BUF-1:0] sel;
  logic any_req, xfer, col, hs, done, retry_ok;
  rr_arbiter_comb #(.N(NUM_BUF)) u_arb (
    .req(buf_valid), .last(last_grant), .grant(arb_grant), .any_req(any_req)
  );
  assign xfer     = state == XFER;
  assign col      = xfer & tx_collision;
  assign hs       = xfer & buf_valid[grant_id] & tx_ready & ~tx_collision;
  assign done     = hs & buf_tail[grant_id];
  assign retry_ok = retry < RW'(MAX_RETRY);
  assign sel      = NUM_BUF'(1) << grant_id;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= IDLE;
      retry      <= '0;
      cnt        <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_BUF - 1);
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        grant_id <= arb_grant;
        retry    <= '0;
      end
      if (col && retry_ok) begin
        cnt   <= CW'((BACKOFF_UNIT << retry) - 1);
        retry <= retry + 1'b1;
      end else if (col || done) begin
        cnt        <= CW'(IFG - 1);
        last_grant <= grant_id;
      end else if (state == BACKOFF || state == GAP)
        cnt <= cnt - 1'b1;
    end
  always_comb
    case (state)
      IDLE:    state_n = any_req ? XFER : IDLE;
      XFER:    state_n = col ? (retry_ok ? BACKOFF : GAP) : (done ? GAP : XFER);
      BACKOFF: state_n = cnt != '0 ? BACKOFF : XFER;
      default: state_n = cnt != '0 ? GAP : IDLE;
    endcase
  always_comb begin
    tx_valid    = xfer & buf_valid[grant_id];
    tx_flit     = xfer ? buf_flit[grant_id*FLIT_W +: FLIT_W] : '0;
    tx_tail     = xfer & buf_tail[grant_id];
    buf_pop     = hs ? sel : '0;
    buf_rewind  = col && retry_ok ? sel : '0;
    buf_discard = col && !retry_ok ? sel : '0;
    drop        = col & ~retry_ok;
    busy        = state != IDLE;
  end
endmodule

// File: tb/tb_tx_buffer_scheduler.sv
// tb_tx_buffer_scheduler: per-cycle directed vectors with hand-computed expectations
module tb_tx_buffer_scheduler;
  localparam int N = 4, FW = 32;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] buf_valid = '0, buf_tail = '0, buf_pop, buf_rewind, buf_discard;
  logic [N*FW-1:0] buf_flit = '0;
  logic tx_valid, tx_tail, busy, drop, tx_ready = 0, tx_collision = 0;
  logic [FW-1:0] tx_flit;
  logic [1:0] grant_id;
  int n_chk = 0, n_fail = 0;
  string phase = "reset";
  typedef struct {
    logic rst; logic [3:0] v, t; logic [31:0] fl; logic rdy, col;
    logic tv, tt; logic [3:0] pop, rw, dc; logic [1:0] g; logic busy, drop;
  } vec_t;
  vec_t tbl[$];
  tx_buffer_scheduler dut (
    .clk(clk), .rst_n(rst_n), .buf_valid(buf_valid), .buf_flit(buf_flit), .buf_tail(buf_tail),
    .buf_pop(buf_pop), .buf_rewind(buf_rewind), .buf_discard(buf_discard), .tx_valid(tx_valid),
    .tx_flit(tx_flit), .tx_tail(tx_tail), .tx_ready(tx_ready), .tx_collision(tx_collision),
    .grant_id(grant_id), .busy(busy), .drop(drop)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] t, logic [31:0] fl, logic rdy,
                              logic col, logic tv, logic tt, logic [3:0] pop, logic [3:0] rw,
                              logic [3:0] dc, logic [1:0] g, logic bz, logic dr);
    vec_t r;
    r.rst = rst; r.v = v; r.t = t; r.fl = fl; r.rdy = rdy; r.col = col; r.tv = tv; r.tt = tt;
    r.pop = pop; r.rw = rw; r.dc = dc; r.g = g; r.busy = bz; r.drop = dr;
    return r;
  endfunction
  task automatic run(input vec_t x);
    logic [17:0] act, exp;
    rst_n = ~x.rst; buf_valid = x.v; buf_tail = x.t; tx_ready = x.rdy; tx_collision = x.col;
    for (int i = 0; i < N; i++) buf_flit[i*FW +: FW] = x.fl + 32'(i * 256);
    @(negedge clk);
    act = {tx_valid, tx_tail, buf_pop, buf_rewind, buf_discard, grant_id, busy, drop};
    exp = {x.tv, x.tt, x.pop, x.rw, x.dc, x.g, x.busy, x.drop};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s chk%0d {tv,tt,pop,rw,dc,g,busy,drop}: got %b required %b", phase, n_chk, act, exp);
    end
    if (x.tv) begin
      n_chk++;
      if (tx_flit !== x.fl + 32'(x.g) * 256) begin
        n_fail++;
        $display("FAIL %s chk%0d tx_flit: got %h required %h", phase, n_chk, tx_flit, x.fl + 32'(x.g) * 256);
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic gap(input logic [3:0] v, input logic [3:0] t, input logic [1:0] g);
    for (int i = 0; i < 4; i++) run(mk(0, v, t, 0, 1, 0, 0, 0, 0, 0, 0, g, 1, 0));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    run(mk(1, 4'hF, 4'hF, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    run(mk(1, 4'hF, 4'hF, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // single 3-flit packet on buffer 0
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // buffers 0 and 2, two single-flit packets each; last grant was 0
    tbl.push_back(mk(0, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5, 5, 16, 1, 0, 1, 1, 4, 0, 0, 2, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 5, 5, 17, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5, 5, 18, 1, 0, 1, 1, 4, 0, 0, 2, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 19, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // 4-flit packet on buffer 3 with toggling tx_ready and one bubble
    tbl.push_back(mk(0, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8, 0, 32, 1, 0, 1, 0, 8, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 8, 0, 33, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 8, 0, 33, 1, 0, 1, 0, 8, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 34, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 8, 0, 34, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 8, 0, 34, 1, 0, 1, 0, 8, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 8, 8, 35, 0, 0, 1, 1, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 8, 8, 35, 1, 0, 1, 1, 8, 0, 0, 3, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0));
    phase = "table";
    foreach (tbl[i]) run(tbl[i]);
    // collision on flit 2 of buffer 1, one 8-cycle backoff, then full resend
    phase = "retry";
    run(mk(0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    run(mk(0, 2, 0, 64, 1, 0, 1, 0, 2, 0, 0, 1, 1, 0));
    run(mk(0, 2, 0, 65, 1, 1, 1, 0, 0, 2, 0, 1, 1, 0));
    for (int i = 0; i < 8; i++) run(mk(0, 2, 0, 0, 1, i == 0, 0, 0, 0, 0, 0, 1, 1, 0));
    run(mk(0, 2, 0, 64, 1, 0, 1, 0, 2, 0, 0, 1, 1, 0));
    run(mk(0, 2, 0, 65, 1, 0, 1, 0, 2, 0, 0, 1, 1, 0));
    run(mk(0, 2, 2, 66, 1, 0, 1, 1, 2, 0, 0, 1, 1, 0));
    gap(0, 0, 1);
    run(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // collisions on every attempt: backoffs 8,16,32 then drop, then buffer 2 served
    phase = "drop";
    run(mk(0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int r = 0; r < 4; r++) begin
      run(mk(0, 6, 0, 80, 1, 1, 1, 0, 0, r < 3 ? 4'd2 : 4'd0, r < 3 ? 4'd0 : 4'd2, 1, 1, r == 3));
      if (r < 3) for (int k = 0; k < (8 << r); k++) run(mk(0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    end
    gap(6, 4, 1);
    run(mk(0, 6, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    run(mk(0, 6, 4, 96, 1, 0, 1, 1, 4, 0, 0, 2, 1, 0));
    gap(0, 0, 2);
    // reset mid-packet: no pulses, then buffer 0 beats buffer 3
    phase = "midreset";
    run(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    run(mk(0, 1, 0, 112, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    run(mk(1, 1, 0, 113, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    run(mk(0, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    run(mk(0, 9, 0, 120, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    run(mk(0, 9, 1, 121, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
